label_pack: RTL and testbench
=============================

LABEL_PACK -- requirements
Module: label_pack

Interface
REQ-001 Parameter IMG_PIXELS, default 1024, SHALL give the label-map size in SRAM words (32x32 raster, row-major).
REQ-002 Parameter LABEL_W, default 8, SHALL give the label width in bits.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be synchronous, active-low reset.
REQ-005 start  input  1  SHALL request one packing pass; sampled only in IDLE.
REQ-006 label_sel  input  8  SHALL select the label to extract; 0 means any nonzero label; latched on start.
REQ-007 sram_q  input  8  SHALL be the label word read from SRAM, valid one cycle after sram_a.
REQ-008 sram_a  output  10  SHALL be the SRAM word address.
REQ-009 sram_wen  output  1  SHALL be the SRAM write enable, active-high, held 0.
REQ-010 out_data  output  8  SHALL carry one packed bitmap byte, pixel 0 in bit 7 (MSB-first, 8 pixels per byte).
REQ-011 out_addr  output  7  SHALL carry the byte index 0..127 of out_data.
REQ-012 out_valid  output  1  SHALL flag out_data/out_addr valid.
REQ-013 out_ready  input  1  SHALL accept a byte when high together with out_valid.
REQ-014 pix_count  output  11  SHALL give the number of matched pixels, 0..1024.
REQ-015 busy  output  1  SHALL be high from start acceptance until done.
REQ-016 done  output  1  SHALL pulse high for one cycle at pass completion.

Function
REQ-017 States SHALL be IDLE, READ, EMIT, DONE.
REQ-018 IDLE->READ SHALL occur on the edge sampling start=1; label_sel, byte index n=0, pix_count=0 latched at that edge.
REQ-019 READ SHALL drive sram_a=8n+k on its k-th cycle, k=0..7, then one drain cycle (9 READ cycles per byte).
REQ-020 Pixel bit SHALL be (sram_q!=0) if latched label_sel==0, else (sram_q==label_sel); bit for address 8n+k lands in out_data[7-k].
REQ-021 pix_count SHALL increment by 1 per matched pixel, saturating never required (max 1024 fits 11 bits).
REQ-022 READ->EMIT after drain; out_valid=1, out_addr=n, byte 0 visible 10 edges after the start-sampling edge.
REQ-023 In EMIT, out_data/out_addr SHALL hold stable while out_valid=1 and out_ready=0, with no SRAM address advance.
REQ-024 On out_valid&out_ready: if n<127, n increments (7-bit) and state returns to READ; if n==127, state goes to DONE.
REQ-025 DONE SHALL assert done for exactly one cycle, drop busy in the same cycle, then return to IDLE; pix_count held until next start.
REQ-026 start while not in IDLE SHALL be ignored; start and done in the same cycle SHALL not launch a pass.
REQ-027 sram_a SHALL hold its last value in IDLE, EMIT and DONE; sram_wen SHALL never assert.

Reset
REQ-028 reset=0 at a rising edge SHALL force IDLE, sram_a=0, sram_wen=0, out_data=0, out_addr=0, out_valid=0, pix_count=0, busy=0, done=0, packer cleared.
REQ-029 Reset mid-pass SHALL abandon the pass with no further out_valid or done pulse until a new start.

Structure
REQ-030 Shared package cle_pkg SHALL hold IMG_PIXELS, BYTES_PER_IMG=128, PIX_PER_BYTE=8 and the state encoding.
REQ-031 One sub-module bit_packer SHALL hold the 8-bit shift register and 3-bit pixel counter.

Verification
REQ-032 All-zero SRAM, label_sel=0 -> 128 bytes 0x00, out_addr 0..127 in order, pix_count=0, one done pulse.
REQ-033 SRAM word 0 = 3, word 9 = 3, word 1023 = 5, rest 0, label_sel=3 -> byte 0=0x80, byte 1=0x40, byte 127=0x00, pix_count=2.
REQ-034 Same map, label_sel=0 -> byte 127=0x01, pix_count=3.
REQ-035 out_ready low 5 cycles on byte 4 -> out_data/out_addr stable, sram_a frozen, then resumes; output identical to no-stall run.
REQ-036 reset low during byte 60 -> next cycle all outputs 0, IDLE; new start yields full correct pass from byte 0.
REQ-037 start pulsed while busy -> ignored, single pass, single done pulse.

Source files
------------

// File: rtl/cle_pkg.sv
// Shared constants and FSM encoding for the label-map bitmap packer.
// Holds the default image size, bytes per image, pixels per packed byte
// and the controller state type.
package cle_pkg;

  // 32x32 raster label map, one label per SRAM word
  localparam int unsigned IMG_PIXELS    = 1024;
  localparam int unsigned PIX_PER_BYTE  = 8;
  localparam int unsigned BYTES_PER_IMG = 128;
  localparam int unsigned PIX_IDX_W     = $clog2(PIX_PER_BYTE);

  // READ counter: 8 address cycles plus one drain cycle
  localparam int unsigned READ_CNT_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/bit_packer.sv
// MSB-first serial-to-parallel packer for one bitmap byte.
// Ports:
//   clk, reset  - clock, synchronous active-low reset
//   clear       - restart a byte (drops partial contents and pixel count)
//   shift       - accept pix_in as the next pixel
//   pix_in      - pixel bit
//   data        - packed byte; the first pixel shifted in ends up in the MSB
//   last_c      - high while the next shift completes the byte
module bit_packer
  import cle_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    shift,
  input  logic                    pix_in,
  output logic [PIX_PER_BYTE-1:0] data,
  output logic                    last_c
);

  logic [PIX_IDX_W-1:0] count;

  // Shift register and pixel counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      data  <= '0;
      count <= '0;
    end else if (clear) begin
      data  <= '0;
      count <= '0;
    end else if (shift) begin
      data  <= {data[PIX_PER_BYTE-2:0], pix_in};
      count <= count + 1'b1;
    end
  end

  assign last_c = (count == PIX_IDX_W'(PIX_PER_BYTE - 1));

endmodule

// File: rtl/label_pack.sv
// Label-map to binary bitmap packer.
// Scans a row-major label map in SRAM, tests every word against a selected
// label (or any nonzero label), and emits the result as MSB-first packed
// bytes over a valid/ready handshake, counting matched pixels.
// Ports:
//   clk, reset           - clock, synchronous active-low reset
//   start, label_sel     - launch one pass (IDLE only) with the label to find
//   sram_q               - SRAM read data, one cycle after sram_a
//   sram_a, sram_wen     - SRAM address / write enable (never written)
//   out_data, out_addr   - packed byte and its byte index
//   out_valid, out_ready - output handshake
//   pix_count            - matched-pixel total for the current/last pass
//   busy, done           - pass in progress / one-cycle completion pulse
module label_pack #(
  parameter  int unsigned IMG_PIXELS = 1024,
  parameter  int unsigned LABEL_W    = 8,
  localparam int unsigned ADDR_W     = $clog2(IMG_PIXELS),
  localparam int unsigned BYTE_W     = cle_pkg::PIX_PER_BYTE,
  localparam int unsigned NUM_BYTES  = IMG_PIXELS / cle_pkg::PIX_PER_BYTE,
  localparam int unsigned IDX_W      = $clog2(NUM_BYTES),
  localparam int unsigned CNT_W      = $clog2(IMG_PIXELS) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [LABEL_W-1:0] label_sel,
  input  logic [LABEL_W-1:0] sram_q,
  output logic [ADDR_W-1:0]  sram_a,
  output logic               sram_wen,
  output logic [BYTE_W-1:0]  out_data,
  output logic [IDX_W-1:0]   out_addr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CNT_W-1:0]   pix_count,
  output logic               busy,
  output logic               done
);

  import cle_pkg::*;

  localparam logic [IDX_W-1:0] LAST_BYTE = IDX_W'(NUM_BYTES - 1);

  state_t                  state;
  logic [LABEL_W-1:0]      sel_q;
  logic [IDX_W-1:0]        byte_idx;
  logic [IDX_W-1:0]        next_idx;
  logic [READ_CNT_W-1:0]   rd_cnt;
  logic                    hit_c;
  logic                    shift_c;
  logic                    clear_c;
  logic                    accept_c;
  logic                    start_c;
  logic [BYTE_W-1:0]       pk_data;
  logic                    pk_last_c;

  // Pixel match: label 0 selects every labelled (nonzero) pixel
  assign hit_c    = (sel_q == '0) ? (sram_q != '0) : (sram_q == sel_q);

  // Word for address 8n+k arrives on READ cycle k+1, so cycle 0 has no data
  assign shift_c  = (state == ST_READ) && (rd_cnt != '0);
  assign start_c  = (state == ST_IDLE) && start;
  assign accept_c = (state == ST_EMIT) && out_valid && out_ready;
  assign clear_c  = start_c || (accept_c && (byte_idx != LAST_BYTE));
  assign next_idx = byte_idx + 1'b1;

  bit_packer u_packer (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear_c),
    .shift  (shift_c),
    .pix_in (hit_c),
    .data   (pk_data),
    .last_c (pk_last_c)
  );

  // Pass controller with registered SRAM address and output handshake
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      sel_q     <= '0;
      byte_idx  <= '0;
      rd_cnt    <= '0;
      sram_a    <= '0;
      sram_wen  <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      out_valid <= 1'b0;
      pix_count <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      sram_wen <= 1'b0;
      done     <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_READ;
            sel_q     <= label_sel;
            byte_idx  <= '0;
            rd_cnt    <= '0;
            sram_a    <= '0;
            pix_count <= '0;
            busy      <= 1'b1;
          end
        end

        ST_READ: begin
          if (shift_c && hit_c) begin
            pix_count <= pix_count + 1'b1;
          end
          // Addresses 8n..8n+7 on cycles 0..7; held through the drain cycle
          if (rd_cnt < READ_CNT_W'(PIX_PER_BYTE - 1)) begin
            sram_a <= sram_a + 1'b1;
          end
          rd_cnt <= rd_cnt + 1'b1;
          if (shift_c && pk_last_c) begin
            state <= ST_EMIT;
          end
        end

        ST_EMIT: begin
          if (!out_valid) begin
            // First EMIT cycle latches the completed byte
            out_valid <= 1'b1;
            out_data  <= pk_data;
            out_addr  <= byte_idx;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            if (byte_idx == LAST_BYTE) begin
              state <= ST_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state    <= ST_READ;
              byte_idx <= next_idx;
              rd_cnt   <= '0;
              sram_a   <= ADDR_W'({next_idx, 3'b000});
            end
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_label_pack.sv
// Directed self-checking bench for label_pack with a synchronous SRAM model.
module tb_label_pack;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  label_sel;
  logic [7:0]  sram_q;
  logic [9:0]  sram_a;
  logic        sram_wen;
  logic [7:0]  out_data;
  logic [6:0]  out_addr;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] pix_count;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  label_pack dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .label_sel (label_sel),
    .sram_q    (sram_q),
    .sram_a    (sram_a),
    .sram_wen  (sram_wen),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pix_count (pix_count),
    .busy      (busy),
    .done      (done)
  );

  // Synchronous-read SRAM: data for an address appears one cycle later
  logic [7:0] mem [0:1023];
  always @(posedge clk) sram_q <= mem[sram_a];

  int wen_seen = 0;
  always @(posedge clk) if (sram_wen === 1'b1) wen_seen <= wen_seen + 1;

  int checks = 0;
  int errors = 0;

  logic [7:0] got   [0:127];
  logic [7:0] exp_b [0:127];
  int n_got, order_err, done_cnt, latency, stall_err, extra;
  logic busy_at_done;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_map(input bit with_labels);
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    if (with_labels) begin
      mem[0]    = 8'd3;
      mem[9]    = 8'd3;
      mem[1023] = 8'd5;
    end
  endtask

  task automatic set_expected(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b127);
    for (int i = 0; i < 128; i++) exp_b[i] = 8'h00;
    exp_b[0]   = b0;
    exp_b[1]   = b1;
    exp_b[127] = b127;
  endtask

  // Runs one pass, collecting accepted bytes; optional stall and start pokes
  task automatic run_pass(input logic [7:0] sel, input int stall_byte, input bit poke_start);
    int   cyc;
    bit   fin;
    bit   stalled;
    logic [7:0] sd;
    logic [6:0] sa;
    logic [9:0] sr;
    for (int i = 0; i < 128; i++) got[i] = 8'hxx;
    n_got = 0; order_err = 0; done_cnt = 0; latency = -1;
    stall_err = 0; extra = 0; busy_at_done = 1'b1;
    label_sel = sel;
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 0; fin = 1'b0; stalled = 1'b0;
    while (!fin && cyc < 4000) begin
      step();
      cyc++;
      start = 1'b0;
      if (done === 1'b1) begin
        done_cnt++;
        busy_at_done = busy;
        fin = 1'b1;
        if (poke_start) start = 1'b1;
      end
      if (out_valid === 1'b1 && latency < 0) latency = cyc;
      if (poke_start && out_valid === 1'b1 && out_addr == 7'd10) start = 1'b1;
      if (out_valid === 1'b1 && out_ready) begin
        if (out_addr !== 7'(n_got)) order_err++;
        if (n_got == stall_byte && !stalled) begin
          stalled = 1'b1;
          out_ready = 1'b0;
          sd = out_data; sa = out_addr; sr = sram_a;
          repeat (5) begin
            step();
            if (out_data !== sd || out_addr !== sa || sram_a !== sr || out_valid !== 1'b1)
              stall_err++;
          end
          out_ready = 1'b1;
        end
        if (n_got < 128) got[n_got] = out_data;
        n_got++;
      end
    end
    for (int i = 0; i < 4; i++) begin
      step();
      start = 1'b0;
      if (out_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) extra++;
    end
  endtask

  task automatic check_bytes(input string name);
    for (int i = 0; i < 128; i++) begin
      checks++;
      if (got[i] !== exp_b[i]) begin
        errors++;
        $display("FAIL %s byte %0d got %h expected %h", name, i, got[i], exp_b[i]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; out_ready = 1'b1; label_sel = 8'd0;
    step(); step();
    checks++;
    if ({sram_a, sram_wen, out_data, out_addr, out_valid, pix_count, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs a=%h wen=%b d=%h oa=%h v=%b pc=%0d busy=%b done=%b expected all 0",
               sram_a, sram_wen, out_data, out_addr, out_valid, pix_count, busy, done);
    end
    reset = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle busy=%b valid=%b expected 0 0", busy, out_valid);
    end
  endtask

  task automatic test_zero_map();
    load_map(1'b0);
    set_expected(8'h00, 8'h00, 8'h00);
    run_pass(8'd0, -1, 1'b0);
    checks++;
    if (latency != 10) begin errors++; $display("FAIL zero_latency got %0d expected 10", latency); end
    checks++;
    if (n_got != 128 || order_err != 0) begin
      errors++; $display("FAIL zero_order bytes %0d order_err %0d expected 128 0", n_got, order_err);
    end
    checks++;
    if (pix_count !== 11'd0) begin errors++; $display("FAIL zero_pix got %0d expected 0", pix_count); end
    checks++;
    if (done_cnt != 1 || busy_at_done !== 1'b0) begin
      errors++; $display("FAIL zero_done pulses %0d busy %b expected 1 0", done_cnt, busy_at_done);
    end
    checks++;
    if (extra != 0) begin errors++; $display("FAIL zero_idle_after got %0d expected 0", extra); end
    check_bytes("zero_map");
  endtask

  task automatic test_label_sel();
    logic [7:0]  sel_t [3] = '{8'd3, 8'd0, 8'd5};
    logic [7:0]  b0_t  [3] = '{8'h80, 8'h80, 8'h00};
    logic [7:0]  b1_t  [3] = '{8'h40, 8'h40, 8'h00};
    logic [7:0]  b127_t[3] = '{8'h00, 8'h01, 8'h01};
    logic [10:0] pc_t  [3] = '{11'd2, 11'd3, 11'd1};
    load_map(1'b1);
    for (int t = 0; t < 3; t++) begin
      set_expected(b0_t[t], b1_t[t], b127_t[t]);
      run_pass(sel_t[t], -1, 1'b0);
      checks++;
      if (pix_count !== pc_t[t]) begin
        errors++; $display("FAIL sel%0d_pix got %0d expected %0d", sel_t[t], pix_count, pc_t[t]);
      end
      checks++;
      if (n_got != 128 || order_err != 0 || done_cnt != 1) begin
        errors++;
        $display("FAIL sel%0d_pass bytes %0d order_err %0d done %0d expected 128 0 1",
                 sel_t[t], n_got, order_err, done_cnt);
      end
      check_bytes($sformatf("sel%0d", sel_t[t]));
    end
  endtask

  task automatic test_stall();
    load_map(1'b1);
    set_expected(8'h80, 8'h40, 8'h01);
    run_pass(8'd0, 4, 1'b0);
    checks++;
    if (stall_err != 0) begin errors++; $display("FAIL stall_hold got %0d changes expected 0", stall_err); end
    checks++;
    if (pix_count !== 11'd3 || n_got != 128 || order_err != 0) begin
      errors++; $display("FAIL stall_pass pix %0d bytes %0d order %0d expected 3 128 0", pix_count, n_got, order_err);
    end
    check_bytes("stall");
  endtask

  task automatic test_reset_mid();
    int cyc;
    int bad;
    load_map(1'b1);
    label_sel = 8'd0; out_ready = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    cyc = 0;
    while (!(out_valid === 1'b1 && out_addr == 7'd60) && cyc < 2000) begin step(); cyc++; end
    checks++;
    if (cyc >= 2000) begin errors++; $display("FAIL midreset_reach byte60 timeout after %0d cycles", cyc); end
    reset = 1'b0;
    step();
    checks++;
    if ({sram_a, out_data, out_addr, out_valid, pix_count, busy, done} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs a=%h d=%h oa=%h v=%b pc=%0d busy=%b done=%b expected all 0",
               sram_a, out_data, out_addr, out_valid, pix_count, busy, done);
    end
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (out_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL midreset_quiet got %0d active cycles expected 0", bad); end
    set_expected(8'h80, 8'h40, 8'h01);
    run_pass(8'd0, -1, 1'b0);
    checks++;
    if (pix_count !== 11'd3 || done_cnt != 1 || latency != 10) begin
      errors++; $display("FAIL midreset_rerun pix %0d done %0d latency %0d expected 3 1 10", pix_count, done_cnt, latency);
    end
    check_bytes("midreset_rerun");
  endtask

  task automatic test_start_busy();
    load_map(1'b1);
    set_expected(8'h80, 8'h40, 8'h01);
    run_pass(8'd0, -1, 1'b1);
    checks++;
    if (done_cnt != 1 || extra != 0) begin
      errors++; $display("FAIL start_busy done %0d extra %0d expected 1 0", done_cnt, extra);
    end
    checks++;
    if (n_got != 128 || order_err != 0 || pix_count !== 11'd3) begin
      errors++; $display("FAIL start_busy_pass bytes %0d order %0d pix %0d expected 128 0 3", n_got, order_err, pix_count);
    end
    check_bytes("start_busy");
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; out_ready = 1'b1; label_sel = 8'd0;
    load_map(1'b0);
    test_reset();
    test_zero_map();
    test_label_sel();
    test_stall();
    test_reset_mid();
    test_start_busy();
    checks++;
    if (wen_seen != 0) begin errors++; $display("FAIL sram_wen got %0d writes expected 0", wen_seen); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
